fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the ARM pipeline IF stage.
- Owns the PC register and issues word requests to instruction memory over a req/ready handshake.
- Delivers {pc+4, instruction, valid} to the IF/ID boundary; obeys freeze (hazard stall) from the hazard unit and taken-branch redirects from EXE.
- Provides a one-entry skid register so no fetched word is lost when a stall arrives.

---
 rtl/arm_pkg.sv | 24 ++
 rtl/fetch_skid_reg.sv | 43 ++++
 rtl/fetch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline IF stage: fetch FSM states,
// word geometry and small PC arithmetic helpers.
package arm_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int          WORD_BYTES = 4;
  localparam int          INSTR_W    = 32;
  localparam logic [31:0] NOP_INSTR  = 32'hE1A0_0000;

  // Next sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'(WORD_BYTES);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry {pc, instr} buffer that catches the word returned in the cycle a
// stall arrives. Clear and unload both empty it; clear wins over load.
module fetch_skid_reg
  import arm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [31:0]        load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               full,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr
);

  logic               full_r;
  logic [31:0]        pc_r;
  logic [INSTR_W-1:0] instr_r;

  // Buffer storage and occupancy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r  <= 1'b0;
      pc_r    <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
    end else if (clear || unload) begin
      full_r  <= 1'b0;
    end else if (load) begin
      full_r  <= 1'b1;
      pc_r    <= load_pc;
      instr_r <= load_instr;
    end else begin
      full_r  <= full_r;
    end
  end

  assign full  = full_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, runs the imem req/ready handshake and
// feeds IF/ID. Optional FETCH_STATS_EN adds delivered-word and stall counters.
module fetch_ctrl
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetch,
  output logic [31:0]        stat_stall
`endif
);

  fetch_state_e       state_r, state_next_s;
  logic [31:0]        pc_r, pc_next_s;
  logic               imem_req_r;
  logic [31:0]        imem_addr_r;
  logic               if_valid_r, if_valid_next_s;
  logic [31:0]        if_pc_r, if_pc_next_s;
  logic [INSTR_W-1:0] if_instr_r, if_instr_next_s;
  logic               skid_load_s, skid_unload_s, skid_clear_s, deliver_s;
  logic               skid_full_s;
  logic [31:0]        skid_pc_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [31:0]        pc_plus4_s, branch_target_s;
  logic               unused_s;

  assign pc_plus4_s      = pc_inc(pc_r);
  assign branch_target_s = word_align(branch_addr);
  assign unused_s        = ^{branch_addr[1:0], skid_full_s};

  fetch_skid_reg u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load_s),
    .unload     (skid_unload_s),
    .clear      (skid_clear_s),
    .load_pc    (pc_plus4_s),
    .load_instr (imem_rdata),
    .full       (skid_full_s),
    .pc         (skid_pc_s),
    .instr      (skid_instr_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a branch overrides freeze and any capture.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          state_next_s = imem_ready ? FETCH : DISCARD;
        end else if (imem_ready && freeze) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken || !freeze) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = HOLD;
        end
      end
      DISCARD: begin
        if (branch_taken) begin
          state_next_s = DISCARD;
        end else if (imem_ready) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = DISCARD;
        end
      end
      default: state_next_s = FETCH;
    endcase
  end

  // Datapath controls: PC advance, IF/ID updates and skid traffic.
  always_comb begin
    pc_next_s       = pc_r;
    if_valid_next_s = if_valid_r;
    if_pc_next_s    = if_pc_r;
    if_instr_next_s = if_instr_r;
    skid_load_s     = 1'b0;
    skid_unload_s   = 1'b0;
    skid_clear_s    = 1'b0;
    deliver_s       = 1'b0;
    if (branch_taken) begin
      pc_next_s       = branch_target_s;
      if_valid_next_s = 1'b0;
      skid_clear_s    = 1'b1;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ready && !freeze) begin
            pc_next_s       = pc_plus4_s;
            if_valid_next_s = 1'b1;
            if_pc_next_s    = pc_plus4_s;
            if_instr_next_s = imem_rdata;
            deliver_s       = 1'b1;
          end else if (imem_ready) begin
            pc_next_s       = pc_plus4_s;
            skid_load_s     = 1'b1;
          end else if (!freeze) begin
            if_valid_next_s = 1'b0;
          end else begin
            pc_next_s       = pc_r;
          end
        end
        HOLD: begin
          if (!freeze) begin
            if_valid_next_s = 1'b1;
            if_pc_next_s    = skid_pc_s;
            if_instr_next_s = skid_instr_s;
            skid_unload_s   = 1'b1;
            deliver_s       = 1'b1;
          end else begin
            pc_next_s       = pc_r;
          end
        end
        DISCARD: pc_next_s = pc_r;
        default: pc_next_s = pc_r;
      endcase
    end
  end

  // PC, registered request and IF/ID outputs. The request address only moves
  // when the next state issues a fresh fetch, so it stays put in DISCARD.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      imem_req_r  <= 1'b1;
      imem_addr_r <= RESET_PC;
      if_valid_r  <= 1'b0;
      if_pc_r     <= 32'h0000_0000;
      if_instr_r  <= 32'h0000_0000;
    end else begin
      pc_r        <= pc_next_s;
      imem_req_r  <= (state_next_s != HOLD);
      imem_addr_r <= (state_next_s == FETCH) ? pc_next_s : imem_addr_r;
      if_valid_r  <= if_valid_next_s;
      if_pc_r     <= if_pc_next_s;
      if_instr_r  <= if_instr_next_s;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign if_valid  = if_valid_r;
  assign if_pc     = if_pc_r;
  assign if_instr  = if_instr_r;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch_r, stat_stall_r;

  // Delivered-word and stall-cycle counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_r <= 32'h0000_0000;
      stat_stall_r <= 32'h0000_0000;
    end else begin
      stat_fetch_r <= deliver_s ? (stat_fetch_r + 32'd1) : stat_fetch_r;
      stat_stall_r <= (freeze || (state_r == FETCH && !imem_ready))
                      ? (stat_stall_r + 32'd1) : stat_stall_r;
    end
  end

  assign stat_fetch = stat_fetch_r;
  assign stat_stall = stat_stall_r;
`else
  logic unused_deliver_s;
  assign unused_deliver_s = deliver_s;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl: per-cycle request checks before the edge
// and IF/ID checks after it, plus a hand-written branch-in-DISCARD sequence.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch, stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetch   (stat_fetch),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] ba;
    logic        rdy;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[27];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic b, input logic [31:0] ba,
                       input logic rdy, input logic [31:0] rd);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    imem_ready = rdy; imem_rdata = rd;
  endtask

  initial begin
    //          rst   frz   br    br_addr       rdy   rdata          req   addr          vld   if_pc         if_instr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hE3A01064, 1'b1, 32'h0,        1'b1, 32'h4,        32'hE3A01064};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hE3A020C8, 1'b1, 32'h4,        1'b1, 32'h8,        32'hE3A020C8};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hE3A03001, 1'b1, 32'h8,        1'b1, 32'hC,        32'hE3A03001};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'hC,        32'hE3A03001};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'hC,        32'hE3A03001};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h11111111, 1'b1, 32'hC,        1'b1, 32'h10,       32'h11111111};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10,       1'b0, 32'h10,       32'h11111111};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10,       1'b0, 32'h10,       32'h11111111};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b1, 32'h10,       1'b1, 32'h14,       32'h22222222};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h33333333, 1'b1, 32'h14,       1'b1, 32'h14,       32'h22222222};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h44444444, 1'b0, 32'h14,       1'b1, 32'h14,       32'h22222222};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h55555555, 1'b0, 32'h14,       1'b1, 32'h14,       32'h22222222};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h66666666, 1'b0, 32'h14,       1'b1, 32'h18,       32'h33333333};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h77777777, 1'b1, 32'h18,       1'b1, 32'h1C,       32'h77777777};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h41,       1'b0, 32'h0,        1'b1, 32'h1C,       1'b0, 32'h1C,       32'h77777777};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h1C,       1'b0, 32'h1C,       32'h77777777};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'h1C,       1'b0, 32'h1C,       32'h77777777};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h88888888, 1'b1, 32'h40,       1'b1, 32'h44,       32'h88888888};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h99999999, 1'b1, 32'h44,       1'b1, 32'h44,       32'h88888888};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 32'h100,      1'b1, 32'hAAAAAAAA, 1'b0, 32'h44,       1'b0, 32'h44,       32'h88888888};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hBBBBBBBB, 1'b1, 32'h100,      1'b1, 32'h104,      32'hBBBBBBBB};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hCCCCCCCC, 1'b1, 32'h104,      1'b0, 32'h104,      32'hBBBBBBBB};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDDDDDDDD, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h0,        32'hDDDDDDDD};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b1, 32'h0,        1'b1, 32'h4,        32'h12345678};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h4,        32'h12345678};
    tbl[25] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        32'h0};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0BADF00D, 1'b1, 32'h0,        1'b1, 32'h4,        32'h0BADF00D};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_req",   {31'h0, imem_req}, 32'h1);
    chk("reset_addr",  imem_addr,         32'h0);
    chk("reset_valid", {31'h0, if_valid}, 32'h0);
    chk("reset_pc",    if_pc,             32'h0);
    chk("reset_instr", if_instr,          32'h0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rst, tbl[i].frz, tbl[i].br, tbl[i].ba, tbl[i].rdy, tbl[i].rd);
      #1;
      n_vec++;
      if (imem_req !== tbl[i].req || imem_addr !== tbl[i].addr) begin
        n_err++;
        $display("FAIL vec%0d_req: got req=%b addr=%h expected req=%b addr=%h",
                 i, imem_req, imem_addr, tbl[i].req, tbl[i].addr);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (if_valid !== tbl[i].vld || if_pc !== tbl[i].pc || if_instr !== tbl[i].ins) begin
        n_err++;
        $display("FAIL vec%0d_ifid: got v=%b pc=%h instr=%h expected v=%b pc=%h instr=%h",
                 i, if_valid, if_pc, if_instr, tbl[i].vld, tbl[i].pc, tbl[i].ins);
      end
      @(negedge clk);
    end

    // Two branches back to back with the old request still outstanding.
    drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("disc_flush_valid", {31'h0, if_valid}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h302, 1'b0, 32'h0);
    #1;
    chk("disc_rebranch_addr", imem_addr, 32'h4);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFEEDFACE);
    #1;
    chk("disc_ready_req",  {31'h0, imem_req}, 32'h1);
    chk("disc_ready_addr", imem_addr,         32'h4);
    @(posedge clk); #1;
    chk("disc_drop_valid", {31'h0, if_valid}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_addr_stable", imem_addr, 32'h300);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5A5A5A5A);
    @(posedge clk); #1;
    chk("after_disc_valid", {31'h0, if_valid}, 32'h1);
    chk("after_disc_pc",    if_pc,             32'h304);
    chk("after_disc_instr", if_instr,          32'h5A5A5A5A);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
